sys_pll_reset_sequencer: RTL and testbench

//  Sequences the system PLL: pulses its reset, waits for lock with timeout and bounded retry,

---
 rtl/sys_pll_reset_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_sys_pll_reset_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sys_pll_reset_sequencer
//  Purpose  : Pulses the PLL reset and waits for lock, with a timeout and a
//             bounded number of retries. Lock must stay stable before the
//             downstream reset is released. While running, loss of lock or a
//             relock request starts the sequence again.
//  Revision : 1.0  initial release
// ============================================================================
module sys_pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int LOCK_STABLE_CYCLES   = 256,
    parameter int RELEASE_DELAY_CYCLES = 8,
    parameter int MAX_RETRIES          = 3
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             pll_locked,
    input  logic                             relock_req,
    input  logic                             lock_lost_clr,
    output logic                             pll_rst,
    output logic                             sys_rst_out,
    output logic                             ready,
    output logic                             fault,
    output logic                             lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

    localparam int C_RC_W    = $clog2(MAX_RETRIES + 1);
    localparam int C_CNT_MAX = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                               ((RST_PULSE_CYCLES > RELEASE_DELAY_CYCLES) ? RST_PULSE_CYCLES : RELEASE_DELAY_CYCLES) :
                               ((LOCK_STABLE_CYCLES > RELEASE_DELAY_CYCLES) ? LOCK_STABLE_CYCLES : RELEASE_DELAY_CYCLES);
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_TCNT_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [C_CNT_W-1:0]  C_PULSE_LAST  = C_CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0]  C_STABLE_LAST = C_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0]  C_REL_LAST    = C_CNT_W'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [C_TCNT_W-1:0] C_TO_LAST     = C_TCNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [C_RC_W-1:0]   C_RETRY_MAX   = C_RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [C_CNT_W-1:0]  r_cnt;        // pulse / stable / release phase counter
    logic [C_CNT_W-1:0]  w_cnt_nxt;
    logic [C_TCNT_W-1:0] r_tcnt;       // cycles since pll_rst release, this attempt
    logic [C_TCNT_W-1:0] w_tcnt_nxt;
    logic [C_RC_W-1:0]   r_retry;
    logic [C_RC_W-1:0]   w_retry_nxt;
    logic                r_sync1;
    logic                r_sync2;
    logic                w_locked_s;
    logic                w_timeout;
    logic                w_lost_set;

    assign w_locked_s  = r_sync2;
    assign w_timeout   = (r_tcnt >= C_TO_LAST);
    assign w_lost_set  = (r_state == S_RUN) && !w_locked_s;
    assign retry_count = r_retry;

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters and retry count register
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state logic; counters stop at their terminal value because every
    // terminal value forces a state change before the counter can wrap
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tcnt_nxt  = r_tcnt;
        w_retry_nxt = r_retry;
        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt >= C_PULSE_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_tcnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK, S_STABLE: begin
                if (w_timeout) begin
                    w_cnt_nxt = '0;
                    if (r_retry == C_RETRY_MAX) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = S_RESET_PLL;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                    if (r_state == S_WAIT_LOCK) begin
                        if (w_locked_s) begin
                            w_state_nxt = S_STABLE;
                            w_cnt_nxt   = '0;
                        end
                    end else if (!w_locked_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= C_STABLE_LAST) begin
                        w_state_nxt = S_RELEASE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_RESET_PLL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= C_REL_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_RESET_PLL;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
        // A relock request overrides whatever the sequence was doing
        if (relock_req) begin
            w_state_nxt = S_RESET_PLL;
            w_cnt_nxt   = '0;
            w_tcnt_nxt  = '0;
            w_retry_nxt = '0;
        end
    end

    // Outputs registered from the next state so they line up with the state
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst     <= 1'b1;
            sys_rst_out <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            pll_rst     <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
            sys_rst_out <= (w_state_nxt != S_RUN);
            ready       <= (w_state_nxt == S_RUN);
            fault       <= (w_state_nxt == S_FAULT);
        end
    end

    // Sticky lock-lost flag; a new loss beats a simultaneous clear
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_lost <= 1'b0;
        end else if (w_lost_set) begin
            lock_lost <= 1'b1;
        end else if (lock_lost_clr) begin
            lock_lost <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sys_pll_reset_sequencer
//  Purpose  : Self-checking bench for sys_pll_reset_sequencer with a
//             phase/run-length reference model and randomized lock traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sys_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 32;
    localparam int P_ST  = 8;
    localparam int P_REL = 3;
    localparam int P_RET = 2;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;   // waiting for lock and qualifying it
    localparam int PH_REL   = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       lock_lost_clr = 1'b0;
    logic       pll_rst, sys_rst_out, ready, fault, lock_lost;
    logic [1:0] retry_count;

    int checks = 0;
    int failures = 0;

    // Model: phase, age within pulse/release, wait cycles, locked run length
    int   m_phase = PH_PULSE, m_age = 0, m_tsince = 0, m_runlen = 0, m_retries = 0;
    bit   m_lost = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0;
    int   div_cycles = 0;
    logic [6:0] first_dut, first_mod;

    sys_pll_reset_sequencer #(
        .RST_PULSE_CYCLES(P_RST), .LOCK_TIMEOUT_CYCLES(P_TO), .LOCK_STABLE_CYCLES(P_ST),
        .RELEASE_DELAY_CYCLES(P_REL), .MAX_RETRIES(P_RET)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
        .lock_lost_clr(lock_lost_clr), .pll_rst(pll_rst), .sys_rst_out(sys_rst_out),
        .ready(ready), .fault(fault), .lock_lost(lock_lost), .retry_count(retry_count)
    );

    always #5 refclk = ~refclk;

    function automatic logic [6:0] model_v();
        return {(m_phase == PH_PULSE || m_phase == PH_FAULT), (m_phase != PH_RUN),
                (m_phase == PH_RUN), (m_phase == PH_FAULT), m_lost, 2'(m_retries)};
    endfunction

    function automatic logic [6:0] dut_v();
        return {pll_rst, sys_rst_out, ready, fault, lock_lost, retry_count};
    endfunction

    // One clock: advance model at the edge, record divergence at the falling edge
    task automatic tick();
        bit ls, lost_set;
        @(posedge refclk);
        ls = m_s2;
        lost_set = (m_phase == PH_RUN) && !ls;
        if (rst) begin
            m_phase = PH_PULSE; m_age = 0; m_tsince = 0; m_runlen = 0; m_retries = 0;
            m_lost = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            if (relock_req) begin
                m_phase = PH_PULSE; m_age = 0; m_retries = 0;
            end else begin
                case (m_phase)
                    PH_PULSE: begin
                        m_age++;
                        if (m_age == P_RST) begin m_phase = PH_WAIT; m_tsince = 0; m_runlen = 0; end
                    end
                    PH_WAIT: begin
                        m_tsince++;
                        if (m_tsince == P_TO) begin
                            if (m_retries == P_RET) m_phase = PH_FAULT;
                            else begin m_retries++; m_phase = PH_PULSE; m_age = 0; end
                        end else if (ls) begin
                            m_runlen++;
                            if (m_runlen == P_ST + 1) begin m_phase = PH_REL; m_age = 0; end
                        end else begin
                            m_runlen = 0;
                        end
                    end
                    PH_REL: begin
                        if (!ls) begin m_phase = PH_PULSE; m_age = 0; end
                        else begin m_age++; if (m_age == P_REL) m_phase = PH_RUN; end
                    end
                    PH_RUN: begin
                        if (!ls) begin m_phase = PH_PULSE; m_age = 0; m_retries = 0; end
                    end
                    default: ;
                endcase
            end
            if (lost_set) m_lost = 1'b1;
            else if (lock_lost_clr) m_lost = 1'b0;
            m_s2 = m_s1;
            m_s1 = pll_locked;
        end
        @(negedge refclk);
        if (dut_v() !== model_v()) begin
            if (div_cycles == 0) begin first_dut = dut_v(); first_mod = model_v(); end
            div_cycles++;
        end
    endtask

    task automatic count_pll_rst(input logic lvl, output int n);
        n = 0;
        while (pll_rst === lvl && n < 100) begin n++; tick(); end
    endtask

    task automatic count_to_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1; tick(); relock_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0;
        tick(); tick();
        checks++; if (dut_v() !== 7'b1100000) begin failures++;
            $display("FAIL reset_values: got %b expected %b", dut_v(), 7'b1100000); end
    endtask

    task automatic test_normal_lock();
        int n;
        rst = 1'b0;
        count_pll_rst(1'b1, n);
        checks++; if (n != P_RST) begin failures++; $display("FAIL normal_pulse_len: got %0d expected %0d", n, P_RST); end
        repeat (10) tick();
        pll_locked = 1'b1;
        count_to_ready(n);
        checks++; if (n != 14) begin failures++; $display("FAIL normal_lock_latency: got %0d expected 14", n); end
        checks++; if (sys_rst_out !== 1'b0 || retry_count !== 2'd0) begin failures++;
            $display("FAIL normal_run_outputs: sys_rst_out=%b retry=%0d expected 0/0", sys_rst_out, retry_count); end
        checks++; if (div_cycles != 0) begin failures++;
            $display("FAIL normal_model: %0d bad cycles, first dut=%b model=%b", div_cycles, first_dut, first_mod); end
    endtask

    task automatic test_timeout_fault();
        int hi, lo;
        pll_locked = 1'b0;
        pulse_relock();
        for (int p = 0; p < 3; p++) begin
            count_pll_rst(1'b1, hi);
            count_pll_rst(1'b0, lo);
            checks++; if (hi != P_RST) begin failures++; $display("FAIL timeout_pulse%0d_len: got %0d expected %0d", p, hi, P_RST); end
            checks++; if (lo != P_TO) begin failures++; $display("FAIL timeout_wait%0d_len: got %0d expected %0d", p, lo, P_TO); end
        end
        repeat (20) tick();
        checks++; if (dut_v() !== 7'b1101010) begin failures++;
            $display("FAIL fault_outputs: got %b expected %b", dut_v(), 7'b1101010); end
        checks++; if (div_cycles != 0) begin failures++;
            $display("FAIL timeout_model: %0d bad cycles, first dut=%b model=%b", div_cycles, first_dut, first_mod); end
    endtask

    task automatic test_relock_from_fault();
        int n;
        pulse_relock();
        checks++; if (dut_v() !== 7'b1100000) begin failures++;
            $display("FAIL relock_clears_fault: got %b expected %b", dut_v(), 7'b1100000); end
        count_pll_rst(1'b1, n);
        checks++; if (n != P_RST) begin failures++; $display("FAIL relock_pulse_len: got %0d expected %0d", n, P_RST); end
        repeat (3) tick();
        pll_locked = 1'b1;
        count_to_ready(n);
        checks++; if (n != 14 || fault !== 1'b0) begin failures++;
            $display("FAIL relock_to_ready: latency %0d fault=%b expected 14/0", n, fault); end
    endtask

    task automatic test_glitch();
        int n;
        pll_locked = 1'b0;
        pulse_relock();
        count_pll_rst(1'b1, n);
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (6) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        count_to_ready(n);
        checks++; if (n != 14 || retry_count !== 2'd0) begin failures++;
            $display("FAIL glitch_relatency: got %0d retry=%0d expected 14/0", n, retry_count); end
        // late lock: timeout wins before qualification completes
        pll_locked = 1'b0;
        pulse_relock();
        count_pll_rst(1'b1, n);
        repeat (25) tick();
        pll_locked = 1'b1;
        repeat (7) tick();
        checks++; if (pll_rst !== 1'b1 || retry_count !== 2'd1 || ready !== 1'b0) begin failures++;
            $display("FAIL glitch_timeout_retry: pll_rst=%b retry=%0d ready=%b expected 1/1/0", pll_rst, retry_count, ready); end
        count_pll_rst(1'b1, n);
        checks++; if (n != P_RST) begin failures++; $display("FAIL glitch_retry_pulse: got %0d expected %0d", n, P_RST); end
        count_to_ready(n);
        checks++; if (ready !== 1'b1 || retry_count !== 2'd1) begin failures++;
            $display("FAIL glitch_retry_ready: ready=%b retry=%0d expected 1/1", ready, retry_count); end
        checks++; if (div_cycles != 0) begin failures++;
            $display("FAIL glitch_model: %0d bad cycles, first dut=%b model=%b", div_cycles, first_dut, first_mod); end
    endtask

    task automatic test_lock_loss();
        int n;
        pll_locked = 1'b0;
        tick(); tick();
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        checks++; if ({lock_lost, sys_rst_out, ready, retry_count} !== 5'b11000) begin failures++;
            $display("FAIL lock_loss_response: lost/sys_rst/ready/retry=%b expected 11000", {lock_lost, sys_rst_out, ready, retry_count}); end
        count_pll_rst(1'b1, n);
        checks++; if (n != P_RST) begin failures++; $display("FAIL lock_loss_pulse: got %0d expected %0d", n, P_RST); end
        lock_lost_clr = 1'b1; tick(); lock_lost_clr = 1'b0;
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL lock_lost_clear: got %b expected 0", lock_lost); end
        pll_locked = 1'b1;
        count_to_ready(n);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL lock_loss_recover: ready=%b expected 1", ready); end
    endtask

    task automatic test_rst_midway();
        int n;
        pll_locked = 1'b0; repeat (4) tick();
        pll_locked = 1'b1;
        count_to_ready(n);
        checks++; if (lock_lost !== 1'b1 || ready !== 1'b1) begin failures++;
            $display("FAIL pre_rst_run: lost=%b ready=%b expected 1/1", lock_lost, ready); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (dut_v() !== 7'b1100000) begin failures++;
            $display("FAIL rst_mid_run: got %b expected %b", dut_v(), 7'b1100000); end
        count_pll_rst(1'b1, n);
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (dut_v() !== 7'b1100000) begin failures++;
            $display("FAIL rst_mid_stable: got %b expected %b", dut_v(), 7'b1100000); end
        count_pll_rst(1'b1, n);
        checks++; if (n != P_RST) begin failures++; $display("FAIL rst_restart_pulse: got %0d expected %0d", n, P_RST); end
        count_to_ready(n);
        checks++; if (ready !== 1'b1 || div_cycles != 0) begin failures++;
            $display("FAIL rst_restart_ready: ready=%b bad_cycles=%0d expected 1/0", ready, div_cycles); end
    endtask

    task automatic test_random();
        int seg = 0, both = 0, runs = 0;
        for (int c = 0; c < 5000; c++) begin
            if (seg == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                seg = pll_locked ? $urandom_range(1, 120) : $urandom_range(1, 150);
            end
            seg--;
            relock_req    = ($urandom_range(0, 299) == 0);
            lock_lost_clr = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 999) == 0);
            tick();
            if (ready === 1'b1 && fault === 1'b1) both++;
            if (ready === 1'b1) runs++;
        end
        rst = 1'b0; relock_req = 1'b0; lock_lost_clr = 1'b0;
        checks++; if (div_cycles != 0) begin failures++;
            $display("FAIL random_model: %0d bad cycles, first dut=%b model=%b", div_cycles, first_dut, first_mod); end
        checks++; if (both != 0) begin failures++; $display("FAIL random_ready_and_fault: got %0d cycles expected 0", both); end
        checks++; if (runs == 0) begin failures++; $display("FAIL random_reached_run: got %0d run cycles expected >0", runs); end
    endtask

    initial begin
        test_reset();
        test_normal_lock();
        test_timeout_fault();
        test_relock_from_fault();
        test_glitch();
        test_lock_loss();
        test_rst_midway();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
